// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed two-digit seven-segment driver. It registers the two
//   result nibbles, lights one digit per refresh slot and puts the
//   registered hex decode of that digit's nibble on the segment lines.
//
//   Ports:
//     clock        system clock, all state on the rising edge
//     reset        asynchronous, active-high reset
//     left_value   left digit nibble (from qout_left)
//     right_value  right digit nibble (from qout_right)
//     blank        1 = both digits dark; the scan keeps running
//     seg          segments {g,f,e,d,c,b,a}, polarity set by COMMON_ANODE
//     an           digit enables, an[0] = right digit, an[1] = left digit
//
//   Parameters:
//     REFRESH_DIV   cycles each digit stays lit (2..65535)
//     COMMON_ANODE  1 = seg/an active-low, 0 = active-high
//     BLINK_LEN     blink window length in cycles (blink build only)
//     BLINK_HALF    blink half-period in cycles (blink build only)
//
//   Optional feature macro: SEG_SCAN_BLINK_ON_CHANGE_EN
//     When defined, a digit whose sampled value changes blinks its enable
//     for BLINK_LEN cycles.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned COMMON_ANODE = 1,
    parameter int unsigned BLINK_LEN    = 64,
    parameter int unsigned BLINK_HALF   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] left_value,
    input  logic [3:0] right_value,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned CW  = $clog2(REFRESH_DIV);
    localparam bit          INV = (COMMON_ANODE != 0);

    if (REFRESH_DIV < 2 || REFRESH_DIV > 65535 || BLINK_HALF == 0 ||
        BLINK_HALF > BLINK_LEN) begin : g_bad_param
        $error("seg_scan_driver: illegal parameter combination");
    end

    typedef enum logic {
        DIGIT_RIGHT = 1'b0,
        DIGIT_LEFT  = 1'b1
    } digit_t;

    digit_t          digit, digit_next;
    logic [CW-1:0]   refresh_cnt;
    logic            wrap;
    logic [3:0]      left_s, right_s;
    logic [3:0]      nibble;
    logic [6:0]      seg_hi, seg_d;
    logic [1:0]      an_hi, an_d;
    logic            blink_off_l, blink_off_r;

    assign wrap = (refresh_cnt == CW'(REFRESH_DIV - 1));

    // Refresh counter, digit state and input samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit       <= DIGIT_RIGHT;
            left_s      <= '0;
            right_s     <= '0;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
            digit       <= digit_next;
            left_s      <= left_value;
            right_s     <= right_value;
        end
    end

    always_comb begin
        digit_next = digit;
        if (wrap) begin
            digit_next = (digit == DIGIT_RIGHT) ? DIGIT_LEFT : DIGIT_RIGHT;
        end
    end

`ifdef SEG_SCAN_BLINK_ON_CHANGE_EN
    localparam int unsigned BW = $clog2(BLINK_LEN + 1);

    logic [BW-1:0] blink_l, blink_r;
    logic [BW-1:0] phase_l, phase_r;

    // A change is detected against the sample register, so the window
    // starts on the same edge that captures the new value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_l <= '0;
            blink_r <= '0;
        end else begin
            if (left_value != left_s)      blink_l <= BW'(BLINK_LEN);
            else if (blink_l != '0)        blink_l <= blink_l - BW'(1);
            if (right_value != right_s)    blink_r <= BW'(BLINK_LEN);
            else if (blink_r != '0)        blink_r <= blink_r - BW'(1);
        end
    end

    assign phase_l     = blink_l / BW'(BLINK_HALF);
    assign phase_r     = blink_r / BW'(BLINK_HALF);
    assign blink_off_l = (blink_l != '0) && phase_l[0];
    assign blink_off_r = (blink_r != '0) && phase_r[0];
`else
    assign blink_off_l = 1'b0;
    assign blink_off_r = 1'b0;
`endif

    // Output decode in active-high form; polarity applied last.
    always_comb begin
        nibble = (digit == DIGIT_LEFT) ? left_s : right_s;
        case (nibble)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase

        if (digit == DIGIT_LEFT) begin
            an_hi = blink_off_l ? 2'b00 : 2'b10;
        end else begin
            an_hi = blink_off_r ? 2'b00 : 2'b01;
        end

        // blank goes straight into the output register: one cycle of lag.
        if (blank) begin
            an_hi  = '0;
            seg_hi = '0;
        end

        seg_d = INV ? ~seg_hi : seg_hi;
        an_d  = INV ? ~an_hi  : an_hi;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg <= INV ? '1 : '0;
            an  <= INV ? '1 : '0;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the authentication system.
- Consumes the two 4-bit result nibbles (`qout_left`, `qout_right`) and drives a time-multiplexed two-digit seven-segment display.
- Contains a refresh counter, a digit-select state and registered hex decode.
- Sits between the system core and the board display pins.

Parameters:
- REFRESH_DIV, 16, clock cycles each digit stays lit; legal range 2..65535.
- COMMON_ANODE, 1, 1 = segment and anode outputs active-low; 0 = active-high.
- BLINK_LEN, 64, blink window length in cycles; used only with BLINK_ON_CHANGE_EN.
- BLINK_HALF, 8, blink half-period in cycles; used only with BLINK_ON_CHANGE_EN.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- left_value  input  4  left digit nibble, driven from `qout_left`.
- right_value  input  4  right digit nibble, driven from `qout_right`.
- blank  input  1  1 = both digits dark; scanning continues.
- seg  output  7  segments {g,f,e,d,c,b,a}; polarity set by COMMON_ANODE.
- an  output  2  digit enables; an[0] = right digit, an[1] = left digit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - refresh counter = 0, digit index = 0 (right).
  - sample registers = 0.
  - `an` = all digits off (2'b11 if COMMON_ANODE, else 2'b00).
  - `seg` = all segments off (7'h7F if COMMON_ANODE, else 7'h00).
- Input sampling: `left_value` and `right_value` are registered every cycle into sample registers.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, digit index toggles (0 = right, 1 = left).
  - Width is $clog2(REFRESH_DIV).
- Output registers: `seg` and `an` are loaded every cycle from the current digit index and the sampled nibble for that digit.
  - Input-to-`seg` latency is 2 cycles.
  - Digit-index change is visible on `an`/`seg` 1 cycle after the toggle edge.
  - `an` and `seg` switch on the same edge; no one-cycle ghosting.
- Decode (active-high form):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - When COMMON_ANODE=1, `seg` is the bitwise inverse.
- Anode (active-high form): index 0 -> 2'b01; index 1 -> 2'b10. When COMMON_ANODE=1, `an` is inverted.
- Blank:
  - Sampled with 1-cycle latency.
  - While the sampled blank is 1, `an` is all-off and `seg` is all-off.
  - Counter and index keep running, so the scan phase is preserved across blank.
- Input change mid-slot: the new value appears on the active digit 2 cycles later, without waiting for the next slot.
- Exactly one digit is enabled at any cycle when not blanked and not in reset.

Optional Feature:
- Macro: SEG_SCAN_BLINK_ON_CHANGE_EN.
- When defined:
  - Each digit has a blink counter.
  - When a digit's new sample differs from its previous sample, that digit's counter loads BLINK_LEN.
  - The counter decrements each cycle to 0; a further change while nonzero reloads it.
  - While a digit's counter is nonzero and (counter / BLINK_HALF) is odd, that digit's `an` bit is forced off during its slot; `seg` still decodes the value.
  - Reset clears both blink counters.
- When not defined: no blink logic; BLINK_LEN and BLINK_HALF are ignored; behaviour is exactly as above.

Test Plan:
- Reset: assert reset mid-scan with COMMON_ANODE=1 -> `an`=2'b11 and `seg`=7'h7F immediately, with no clock edge. Release reset with left=0, right=0 -> by the 2nd edge `an`=2'b10, `seg`=7'h40.
- Steady scan: REFRESH_DIV=4, left=4'hC, right=4'hA -> `an` alternates 2'b10/2'b01 every 4 cycles. `seg`=7'h08 while right is lit; `seg`=7'h46 while left is lit.
- Mid-slot change: right changes 4'hA -> 4'h5 while right is lit -> `seg`=7'h12 exactly 2 cycles later, and `an` is unchanged.
- Blank: pulse blank for 6 cycles -> `an`=2'b11 for those cycles (1-cycle lag). On release, the scan index matches an uninterrupted run.
- Polarity: COMMON_ANODE=0, left=4'h8, right=4'h1 -> `an`=2'b01 with `seg`=7'h06, then `an`=2'b10 with `seg`=7'h7F.
- Blink (with SEG_SCAN_BLINK_ON_CHANGE_EN, BLINK_LEN=16, BLINK_HALF=4): change left 3 -> 7 -> left `an` bit is forced off during its slot in cycles where (count/4) is odd, for 16 cycles. The right digit is unaffected.
